// File: rtl/vfifo_line_writer_if.sv
// Bus interface for vfifo_line_writer: FIFO read port, line RAM write port
// and the line handshake towards the HDMI-side reader.
// The master modport is the writer; the slave modport is its environment.
interface vfifo_line_writer_if #(
    parameter int ADDR_W = 11
);
    // FIFO read port
    logic [28:0]     fifo_dout;
    logic            fifo_empty;
    logic            fifo_rd_en;

    // Ping-pong line RAM write port
    logic            ram_we;
    logic [ADDR_W:0] ram_addr;
    logic [15:0]     ram_wdata;

    // Line handshake and error pulses
    logic            line_done;
    logic [10:0]     line_y;
    logic            line_bank;
    logic            line_ack;
    logic            seg_err;
    logic            ovf_err;

    modport master (
        input  fifo_dout,
        input  fifo_empty,
        output fifo_rd_en,
        output ram_we,
        output ram_addr,
        output ram_wdata,
        output line_done,
        output line_y,
        output line_bank,
        input  line_ack,
        output seg_err,
        output ovf_err
    );

    modport slave (
        output fifo_dout,
        output fifo_empty,
        input  fifo_rd_en,
        input  ram_we,
        input  ram_addr,
        input  ram_wdata,
        input  line_done,
        input  line_y,
        input  line_bank,
        output line_ack,
        input  seg_err,
        input  ovf_err
    );
endinterface

// File: rtl/vfifo_line_writer.sv
// vfifo_line_writer: pops 29-bit video words {rsv, half, y, pixel} from the
// receiver FIFO, reassembles the two half-line segments of each video line
// and writes the pixels into a two-bank (ping-pong) line RAM. A completed
// line is announced with line_done; the reader returns banks with line_ack.
// A word arriving while the target bank is still owned by the reader is
// parked in a one-entry hold register until that bank is released.
//
// Optional feature: define VFIFO_YRANGE_CHECK_EN to discard words whose
// y is outside 0..V_LINES-1 (ovf_err pulse, line state untouched).
module vfifo_line_writer #(
    parameter int HALF_PIX = 640,
    parameter int ADDR_W   = 11,
    parameter int V_LINES  = 720
) (
    input  logic                 clk125,
    input  logic                 sys_rst,
    vfifo_line_writer_if.master  bus
);

    // Parameter sanity: both halves must fit one bank, y must fit 11 bits.
    if (2 * HALF_PIX > (1 << ADDR_W) || V_LINES < 1 || V_LINES > 2048) begin : g_bad_cfg
        $error("vfifo_line_writer: invalid HALF_PIX/ADDR_W/V_LINES combination");
    end

    localparam logic [ADDR_W-1:0] HALF_PIX_A = ADDR_W'(HALF_PIX);
    localparam logic [ADDR_W-1:0] LAST_PIX   = ADDR_W'(HALF_PIX - 1);
`ifdef VFIFO_YRANGE_CHECK_EN
    localparam logic [31:0]       V_LINES_U  = 32'(V_LINES);
`endif

    // Controller states
    localparam logic [1:0] ST_IDLE      = 2'd0;  // no line active
    localparam logic [1:0] ST_FILL      = 2'd1;  // line active
    localparam logic [1:0] ST_WAIT_BANK = 2'd2;  // word parked, target bank busy

    // Control state
    logic [1:0]        state_q, state_d;
    logic              wr_bank_q, wr_bank_d;
    logic              rd_bank_q, rd_bank_d;
    logic [1:0]        full_q, full_d;
    logic [1:0]        mask_q, mask_d;
    logic [ADDR_W-1:0] pix_cnt_q, pix_cnt_d;
    logic [10:0]       cur_y_q, cur_y_d;
    logic              cur_half_q, cur_half_d;
    logic              rd_vld_q;

    // Hold register payload (meaningful only in ST_WAIT_BANK)
    logic [27:0]       hold_word_q, hold_word_d;

    // Registered outputs
    logic              ram_we_q, ram_we_d;
    logic [ADDR_W:0]   ram_addr_q, ram_addr_d;
    logic [15:0]       ram_wdata_q, ram_wdata_d;
    logic              line_done_q, line_done_d;
    logic [10:0]       line_y_q, line_y_d;
    logic              line_bank_q, line_bank_d;
    logic              seg_err_q, seg_err_d;
    logic              ovf_err_q, ovf_err_d;

    // Word decode and processing scratch
    logic              pop;
    logic              proc;
    logic [27:0]       word;
    logic              w_half;
    logic [10:0]       w_y;
    logic [15:0]       w_pix;
    logic              line_active;
    logic              y_ok;
    logic              do_write;
    logic              full_set;
    logic [1:0]        eff_mask;
    logic [ADDR_W-1:0] eff_pix;
    logic [10:0]       eff_y;
    logic [ADDR_W-1:0] bank_offs;

    // The reserved bit is carried by the FIFO but has no meaning here.
    logic              unused_rsv;
    assign unused_rsv = bus.fifo_dout[28];

    // Pop whenever a word is available, its target bank is free and the hold
    // register is empty; never pop while reset is applied.
    assign pop = !sys_rst && !bus.fifo_empty && !full_q[wr_bank_q] &&
                 (state_q != ST_WAIT_BANK);

    assign line_active = (state_q == ST_FILL);

    // Next-state logic: select the word, apply the line rules, update bank flags.
    always_comb begin
        // NOTE: every variable driven here gets a default first, so no path
        // leaves one unassigned and no latch can be inferred.
        state_d     = state_q;
        wr_bank_d   = wr_bank_q;
        rd_bank_d   = rd_bank_q;
        full_d      = full_q;
        mask_d      = mask_q;
        pix_cnt_d   = pix_cnt_q;
        cur_y_d     = cur_y_q;
        cur_half_d  = cur_half_q;
        hold_word_d = hold_word_q;

        ram_we_d    = 1'b0;
        ram_addr_d  = ram_addr_q;
        ram_wdata_d = ram_wdata_q;
        line_done_d = 1'b0;
        line_y_d    = line_y_q;
        line_bank_d = line_bank_q;
        seg_err_d   = 1'b0;
        ovf_err_d   = 1'b0;

        proc        = 1'b0;
        word        = hold_word_q;
        do_write    = 1'b0;
        full_set    = 1'b0;
        eff_mask    = mask_q;
        eff_pix     = pix_cnt_q;
        eff_y       = cur_y_q;
        bank_offs   = '0;

        // Word source: the parked word once its bank frees up, otherwise the
        // word popped in the previous cycle (parked if its bank is busy).
        if (state_q == ST_WAIT_BANK) begin
            proc = !full_q[wr_bank_q];
        end else if (rd_vld_q) begin
            word = bus.fifo_dout[27:0];
            if (full_q[wr_bank_q]) begin
                hold_word_d = bus.fifo_dout[27:0];
                state_d     = ST_WAIT_BANK;
            end else begin
                proc = 1'b1;
            end
        end

        w_half = word[27];
        w_y    = word[26:16];
        w_pix  = word[15:0];

`ifdef VFIFO_YRANGE_CHECK_EN
        y_ok = ({21'd0, w_y} < V_LINES_U);
`else
        y_ok = 1'b1;
`endif

        if (proc) begin
            state_d = line_active ? ST_FILL : ST_IDLE;

            if (!y_ok) begin
                // Out-of-range line number: drop the word, keep line state.
                ovf_err_d = 1'b1;
            end else if (!line_active) begin
                // First word of a new line.
                eff_y      = w_y;
                eff_mask   = 2'b00;
                cur_half_d = w_half;
                eff_pix    = '0;
                do_write   = 1'b1;
            end else if (w_y != cur_y_q) begin
                // New line before the current one completed: abandon it and
                // restart in the same bank.
                seg_err_d  = (mask_q != 2'b11);
                eff_y      = w_y;
                eff_mask   = 2'b00;
                cur_half_d = w_half;
                eff_pix    = '0;
                do_write   = 1'b1;
            end else if (w_half != cur_half_q) begin
                // Switch to the other half-line segment.
                cur_half_d = w_half;
                eff_pix    = '0;
                do_write   = 1'b1;
            end else if (mask_q[w_half] || pix_cnt_q >= HALF_PIX_A) begin
                // Segment already complete: excess word.
                ovf_err_d = 1'b1;
            end else begin
                do_write = 1'b1;
            end

            if (do_write) begin
                bank_offs   = w_half ? (HALF_PIX_A + eff_pix) : eff_pix;
                ram_we_d    = 1'b1;
                ram_addr_d  = {wr_bank_q, bank_offs};
                ram_wdata_d = w_pix;
                pix_cnt_d   = eff_pix + 1'b1;
                state_d     = ST_FILL;
                if (eff_pix == LAST_PIX) begin
                    eff_mask[w_half] = 1'b1;
                end
                if (eff_mask == 2'b11) begin
                    // Both halves present: hand the bank to the reader.
                    line_done_d = 1'b1;
                    line_y_d    = eff_y;
                    line_bank_d = wr_bank_q;
                    full_set    = 1'b1;
                    wr_bank_d   = ~wr_bank_q;
                    state_d     = ST_IDLE;
                end
            end

            mask_d  = eff_mask;
            cur_y_d = eff_y;
        end

        // Bank ownership: an ack releases the reader's oldest full bank and
        // is judged on the flags before this cycle's completion. The two
        // updates never touch the same bank (the written bank was free).
        if (bus.line_ack && full_q[rd_bank_q]) begin
            full_d[rd_bank_q] = 1'b0;
            rd_bank_d         = ~rd_bank_q;
        end
        if (full_set) begin
            full_d[wr_bank_q] = 1'b1;
        end
    end

    // Control and output registers with synchronous reset.
    always_ff @(posedge clk125) begin
        // NOTE: clocked state uses non-blocking assignments so every register
        // samples the pre-edge values, independent of statement order.
        if (sys_rst) begin
            state_q     <= ST_IDLE;
            wr_bank_q   <= 1'b0;
            rd_bank_q   <= 1'b0;
            full_q      <= 2'b00;
            mask_q      <= 2'b00;
            pix_cnt_q   <= '0;
            cur_y_q     <= '0;
            cur_half_q  <= 1'b0;
            rd_vld_q    <= 1'b0;
            ram_we_q    <= 1'b0;
            ram_addr_q  <= '0;
            ram_wdata_q <= '0;
            line_done_q <= 1'b0;
            line_y_q    <= '0;
            line_bank_q <= 1'b0;
            seg_err_q   <= 1'b0;
            ovf_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            wr_bank_q   <= wr_bank_d;
            rd_bank_q   <= rd_bank_d;
            full_q      <= full_d;
            mask_q      <= mask_d;
            pix_cnt_q   <= pix_cnt_d;
            cur_y_q     <= cur_y_d;
            cur_half_q  <= cur_half_d;
            rd_vld_q    <= pop;
            ram_we_q    <= ram_we_d;
            ram_addr_q  <= ram_addr_d;
            ram_wdata_q <= ram_wdata_d;
            line_done_q <= line_done_d;
            line_y_q    <= line_y_d;
            line_bank_q <= line_bank_d;
            seg_err_q   <= seg_err_d;
            ovf_err_q   <= ovf_err_d;
        end
    end

    // Hold register payload.
    always_ff @(posedge clk125) begin
        // NOTE: pure data registers are left without reset; the state
        // register decides when their content is used.
        hold_word_q <= hold_word_d;
    end

    assign bus.fifo_rd_en = pop;
    assign bus.ram_we     = ram_we_q;
    assign bus.ram_addr   = ram_addr_q;
    assign bus.ram_wdata  = ram_wdata_q;
    assign bus.line_done  = line_done_q;
    assign bus.line_y     = line_y_q;
    assign bus.line_bank  = line_bank_q;
    assign bus.seg_err    = seg_err_q;
    assign bus.ovf_err    = ovf_err_q;

endmodule

// File: tb/tb_vfifo_line_writer.sv
// Self-checking bench for vfifo_line_writer. A FIFO model feeds words; each
// pushed word is run through a line-reassembly reference model whose
// predicted RAM write / error / line_done response is queued. A monitor acts
// as the HDMI reader (line_ack), tracks bank ownership and pops expectations
// whenever the DUT shows an output event.
`timescale 1ns/1ps
module tb_vfifo_line_writer;

    localparam int HALF_PIX = 640;
    localparam int ADDR_W   = 11;
    localparam int V_LINES  = 720;

    typedef struct packed {
        logic            we;
        logic [ADDR_W:0] addr;
        logic [15:0]     data;
        logic            done;
        logic [10:0]     y;
        logic            bank;
        logic            seg;
        logic            ovf;
    } exp_t;

    logic clk = 1'b0;
    logic sys_rst = 1'b1;
    always #5 clk = ~clk;

    vfifo_line_writer_if #(.ADDR_W(ADDR_W)) bus ();

    vfifo_line_writer #(
        .HALF_PIX (HALF_PIX),
        .ADDR_W   (ADDR_W),
        .V_LINES  (V_LINES)
    ) dut (
        .clk125  (clk),
        .sys_rst (sys_rst),
        .bus     (bus.master)
    );

    int          checks   = 0;
    int          errors   = 0;
    int          done_cnt = 0;
    logic [28:0] fifo_q[$];
    exp_t        exp_q[$];
    int          gap_mode = 0;
    bit          ack_en   = 1'b0;

    // Reader-side view of bank ownership
    bit [1:0]    m_full = 2'b00;
    bit          m_rd   = 1'b0;

    // Reference model of the line being assembled
    bit          m_active = 1'b0;
    logic [10:0] m_y      = '0;
    bit          m_half   = 1'b0;
    int          m_pix    = 0;
    bit [1:0]    m_mask   = 2'b00;
    bit          m_bank   = 1'b0;

    // FIFO driver state
    bit          popped = 1'b0;
    logic [28:0] pend   = '0;
    bit          tog    = 1'b0;
    bit          gap    = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp_v, $time);
        end
    endtask

    task automatic finish_run();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    endtask

    function automatic void model_reset();
        m_active = 1'b0;
        m_y      = '0;
        m_half   = 1'b0;
        m_pix    = 0;
        m_mask   = 2'b00;
        m_bank   = 1'b0;
    endfunction

    // Expected response to one word, from the line reassembly rules.
    function automatic exp_t model_word(input logic [28:0] w);
        exp_t        e;
        logic [10:0] y;
        bit          h;
        bit          wr;
        e  = '0;
        y  = w[26:16];
        h  = w[27];
        wr = 1'b0;
`ifdef VFIFO_YRANGE_CHECK_EN
        if (int'(y) >= V_LINES) begin
            e.ovf = 1'b1;
            return e;
        end
`endif
        if (!m_active || y != m_y) begin
            if (m_active) e.seg = (m_mask != 2'b11);
            m_active = 1'b1;
            m_y      = y;
            m_mask   = 2'b00;
            m_half   = h;
            m_pix    = 0;
            wr       = 1'b1;
        end else if (h != m_half) begin
            m_half = h;
            m_pix  = 0;
            wr     = 1'b1;
        end else if (m_mask[h] || m_pix >= HALF_PIX) begin
            e.ovf = 1'b1;
        end else begin
            wr = 1'b1;
        end
        if (wr) begin
            e.we   = 1'b1;
            e.addr = {m_bank, ADDR_W'(h ? HALF_PIX + m_pix : m_pix)};
            e.data = w[15:0];
            if (m_pix == HALF_PIX - 1) m_mask[h] = 1'b1;
            m_pix++;
            if (m_mask == 2'b11) begin
                e.done   = 1'b1;
                e.y      = m_y;
                e.bank   = m_bank;
                m_bank   = ~m_bank;
                m_active = 1'b0;
            end
        end
        return e;
    endfunction

    task automatic push_word(input logic [10:0] y, input logic h, input logic [15:0] p);
        logic [28:0] w;
        w = {1'($urandom), h, y, p};
        fifo_q.push_back(w);
        exp_q.push_back(model_word(w));
    endtask

    task automatic push_line(input logic [10:0] y);
        for (int h = 0; h < 2; h++)
            for (int i = 0; i < HALF_PIX; i++)
                push_word(y, h[0], 16'($urandom));
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((fifo_q.size() != 0 || exp_q.size() != 0) && n < 30000) begin
            @(negedge clk);
            n++;
        end
        if (fifo_q.size() != 0 || exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: %0d words and %0d expectations left", fifo_q.size(), exp_q.size());
            finish_run();
        end
        repeat (5) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        sys_rst = 1'b1;
        repeat (2) @(negedge clk);
        model_reset();
        sys_rst = 1'b0;
    endtask

    // FIFO model: data appears one cycle after the pop.
    initial begin
        bus.fifo_dout  = '0;
        bus.fifo_empty = 1'b1;
        forever begin
            @(negedge clk);
            bus.fifo_dout = popped ? pend : 29'($urandom);
            popped = 1'b0;
            tog    = ~tog;
            case (gap_mode)
                1:       gap = tog;
                2:       gap = ($urandom_range(0, 2) == 0);
                default: gap = 1'b0;
            endcase
            bus.fifo_empty = (fifo_q.size() == 0) || gap;
            #4;
            if (bus.fifo_rd_en) begin
                check("pop_only_when_nonempty", 32'(bus.fifo_empty), 32'd0);
                if (!bus.fifo_empty) begin
                    pend   = fifo_q.pop_front();
                    popped = 1'b1;
                end
            end
        end
    end

    // Monitor / scoreboard and reader model.
    initial begin
        exp_t e;
        bit   ack_now;
        bus.line_ack = 1'b0;
        forever begin
            @(negedge clk);
            if (sys_rst) begin
                m_full       = 2'b00;
                m_rd         = 1'b0;
                bus.line_ack = 1'b0;
            end else begin
                ack_now = bus.line_ack;
                if (bus.ram_we)
                    check("write_to_free_bank", 32'(m_full[bus.ram_addr[ADDR_W]]), 32'd0);
                if (bus.ram_we || bus.seg_err || bus.ovf_err || bus.line_done) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_output: we=%0b addr=%0h seg=%0b ovf=%0b done=%0b, none required",
                                 bus.ram_we, bus.ram_addr, bus.seg_err, bus.ovf_err, bus.line_done);
                    end else begin
                        e = exp_q.pop_front();
                        check("ram_we", 32'(bus.ram_we), 32'(e.we));
                        if (e.we) begin
                            check("ram_addr", 32'(bus.ram_addr), 32'(e.addr));
                            check("ram_wdata", 32'(bus.ram_wdata), 32'(e.data));
                        end
                        check("line_done", 32'(bus.line_done), 32'(e.done));
                        if (e.done) begin
                            check("line_y", 32'(bus.line_y), 32'(e.y));
                            check("line_bank", 32'(bus.line_bank), 32'(e.bank));
                        end
                        check("seg_err", 32'(bus.seg_err), 32'(e.seg));
                        check("ovf_err", 32'(bus.ovf_err), 32'(e.ovf));
                    end
                end
                if (ack_now && m_full[m_rd]) begin
                    m_full[m_rd] = 1'b0;
                    m_rd         = ~m_rd;
                end
                if (bus.line_done) begin
                    m_full[bus.line_bank] = 1'b1;
                    done_cnt++;
                end
                if (m_full == 2'b11)
                    check("no_pop_when_both_full", 32'(bus.fifo_rd_en), 32'd0);
                if (ack_en && m_full != 2'b00)
                    bus.line_ack = ($urandom_range(0, 3) == 0);
                else if (ack_en)
                    bus.line_ack = ($urandom_range(0, 15) == 0);
                else
                    bus.line_ack = 1'b0;
            end
        end
    end

    // Stimulus sequence.
    initial begin
        int d0;
        int n;
        sys_rst = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_fifo_rd_en", 32'(bus.fifo_rd_en), 32'd0);
        check("rst_ram_we", 32'(bus.ram_we), 32'd0);
        check("rst_ram_addr", 32'(bus.ram_addr), 32'd0);
        check("rst_ram_wdata", 32'(bus.ram_wdata), 32'd0);
        check("rst_line_done", 32'(bus.line_done), 32'd0);
        check("rst_line_y", 32'(bus.line_y), 32'd0);
        check("rst_line_bank", 32'(bus.line_bank), 32'd0);
        check("rst_seg_err", 32'(bus.seg_err), 32'd0);
        check("rst_ovf_err", 32'(bus.ovf_err), 32'd0);
        sys_rst = 1'b0;

        // One full line, pixel = index, addresses 0..1279 in bank 0.
        ack_en = 1'b1;
        d0 = done_cnt;
        for (int h = 0; h < 2; h++)
            for (int i = 0; i < HALF_PIX; i++)
                push_word(11'd5, h[0], 16'(h * HALF_PIX + i));
        drain();
        check("first_line_done_count", 32'(done_cnt - d0), 32'd1);

        // Both banks full: the first word of line 3 is parked until an ack.
        do_reset();
        ack_en = 1'b0;
        push_line(11'd1);
        push_line(11'd2);
        push_line(11'd3);
        n = 0;
        while (exp_q.size() > 2 * HALF_PIX && n < 10000) begin
            @(negedge clk);
            n++;
        end
        repeat (20) @(negedge clk);
        check("stall_words_left_in_fifo", 32'(fifo_q.size()), 32'(2 * HALF_PIX - 1));
        check("stall_line3_unwritten", 32'(exp_q.size()), 32'(2 * HALF_PIX));
        ack_en = 1'b1;
        drain();

        // Abandoned line: 300 words of y=7, then line y=8.
        do_reset();
        for (int i = 0; i < 300; i++) push_word(11'd7, 1'b0, 16'($urandom));
        push_line(11'd8);
        drain();

        // Overlong segment: 641 words in one half.
        for (int i = 0; i < HALF_PIX + 1; i++) push_word(11'd3, 1'b0, 16'($urandom));
        drain();

        // FIFO empty toggling every cycle during a line.
        gap_mode = 1;
        d0 = done_cnt;
        push_line(11'd4);
        drain();
        check("toggle_line_done_count", 32'(done_cnt - d0), 32'd1);
        gap_mode = 0;

        // Reset mid-line: no error pulse, next line starts cleanly.
        for (int i = 0; i < 100; i++) push_word(11'd10, 1'b0, 16'($urandom));
        drain();
        do_reset();
        push_line(11'd11);
        drain();

        // Line number at the range boundary.
        push_word(11'd720, 1'b0, 16'h1234);
        push_line(11'd12);
        drain();

        // Randomized traffic with gaps and random acks.
        gap_mode = 2;
        for (int r = 0; r < 12; r++) begin
            case ($urandom_range(0, 3))
                0: push_line(11'($urandom_range(0, 15)));
                1: begin
                    logic [10:0] y;
                    logic        h;
                    int          len;
                    y   = 11'($urandom_range(0, 15));
                    h   = 1'($urandom);
                    len = $urandom_range(1, HALF_PIX + 60);
                    for (int i = 0; i < len; i++) push_word(y, h, 16'($urandom));
                end
                2: for (int i = 0; i < 6; i++)
                    push_word(11'($urandom_range(0, 3)), 1'($urandom), 16'($urandom));
                default: begin
                    push_word(11'($urandom_range(V_LINES, V_LINES + 3)), 1'($urandom), 16'($urandom));
                    push_line(11'($urandom_range(0, 15)));
                end
            endcase
        end
        drain();
        gap_mode = 0;

        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        finish_run();
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

endmodule
